// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for a bank of common-anode 7-segment
// digits sharing one hex-to-segment decoder. Each slot presents one nibble
// of the displayed word and pulls the matching anode low after a short
// anti-ghosting blank. Displayed words are swapped only on frame wrap so a
// mid-frame load never tears the display.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,  // cycles per digit slot, >= 2
  parameter int BLANK_CYCLES = 16      // dark cycles at slot start, < REFRESH_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    lz_en,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_an_n,
  output logic                    frame_tick
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  // Architectural state
  logic [DATA_W-1:0] pending_reg, pending_next;   // last loaded word
  logic [DATA_W-1:0] active_reg,  active_next;    // word being displayed
  logic              lz_reg,      lz_next;        // suppression, latched per frame
  logic [IDX_W-1:0]  idx_reg,     idx_next;       // current digit
  logic [CNT_W-1:0]  cnt_reg,     cnt_next;       // position within the slot
  logic              scan_on_reg, scan_on_next;   // enable as seen on the last edge
  logic              tick_reg,    tick_next;      // frame wrap pulse

  // Slot and frame boundaries, decoded from the current state
  logic slot_end;
  logic frame_wrap;

  assign slot_end   = (cnt_reg == CNT_LAST);
  assign frame_wrap = slot_end && (idx_reg == IDX_LAST);

  // Next-state logic for the scan counters and display buffers
  always_comb begin
    pending_next = load ? data_in : pending_reg;
    active_next  = active_reg;
    lz_next      = lz_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    tick_next    = 1'b0;
    scan_on_next = enable;

    if (!enable) begin
      // Held scan: park at digit 0 and keep the displayed word current so
      // the first enabled frame shows the latest load.
      idx_next    = '0;
      cnt_next    = '0;
      active_next = pending_next;
      lz_next     = lz_en;
    end else begin
      if (slot_end) begin
        cnt_next = '0;
        idx_next = frame_wrap ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end

      if (frame_wrap) begin
        // A load in the wrap cycle itself is taken into the new frame.
        active_next = pending_next;
        lz_next     = lz_en;
        tick_next   = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      active_reg  <= '0;
      lz_reg      <= 1'b0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      scan_on_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      active_reg  <= active_next;
      lz_reg      <= lz_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      scan_on_reg <= scan_on_next;
      tick_reg    <= tick_next;
    end
  end

  // Per-digit views of the displayed word and leading-zero detection
  logic [3:0]            digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;   // nibbles k..NUM_DIGITS-1 all zero
  logic [NUM_DIGITS-1:0] suppress;     // digit k blanked as a leading zero

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_nib[gi]  = active_reg[4*gi +: 4];
    assign upper_zero[gi] = (active_reg[DATA_W-1:4*gi] == '0);

    // Digit 0 always shows, so a zero word still displays a single "0".
    if (gi == 0) begin : g_lsd
      assign suppress[gi] = 1'b0;
    end else begin : g_upper
      assign suppress[gi] = lz_reg && upper_zero[gi];
    end
  end

  // Anodes light only in the lit part of an enabled slot
  logic lit_window;

  assign lit_window = scan_on_reg && (cnt_reg >= CNT_BLANK);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign digit_an_n[gi] = ~(lit_window && (idx_reg == IDX_W'(gi)) && !suppress[gi]);
  end

  // Nibble changes together with idx, during the blank window, so the
  // decoder has settled before the anode turns on.
  assign nibble     = scan_on_reg ? digit_nib[idx_reg] : 4'h0;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots,
// 2-cycle blank). A behavioural model pushes the expected outputs for each
// clock edge into a queue; the opposite edge pops and compares them.
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  nibble;
  logic [3:0]  digit_an_n;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lit_cnt [4];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .data_in   (data_in),
    .lz_en     (lz_en),
    .nibble    (nibble),
    .digit_an_n(digit_an_n),
    .frame_tick(frame_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    int          idx;
    int          cnt;
    logic [15:0] pend;
    logic [15:0] act;
    logic        lz;
    logic        en;
    logic        tick;
  } mstate_t;

  mstate_t    m;
  logic [8:0] sb [$];

  function automatic mstate_t next_state(mstate_t s, logic en, logic ld, logic [15:0] d, logic lz);
    mstate_t r;
    logic    wrap;
    r      = s;
    r.pend = ld ? d : s.pend;
    wrap   = en && (s.idx == N - 1) && (s.cnt == RD - 1);
    r.tick = wrap;
    r.en   = en;
    if (!en) begin
      r.idx = 0;
      r.cnt = 0;
      r.act = r.pend;
      r.lz  = lz;
    end else begin
      r.cnt = (s.cnt + 1) % RD;
      if (s.cnt == RD - 1) r.idx = (s.idx + 1) % N;
      if (wrap) begin
        r.act = r.pend;
        r.lz  = lz;
      end
    end
    return r;
  endfunction

  // Expected {nibble, digit_an_n, frame_tick} for a model state
  function automatic logic [8:0] exp_of(mstate_t s);
    logic [3:0]  nib;
    logic [3:0]  an;
    logic [15:0] upper;
    nib   = 4'h0;
    an    = 4'hF;
    upper = s.act >> (4 * s.idx);
    if (s.en) nib = upper[3:0];
    if (s.en && s.cnt >= BL && !(s.idx > 0 && s.lz && upper == 16'h0000))
      an[s.idx] = 1'b0;
    return {nib, an, s.tick};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      sb.delete();
    end else begin
      m <= next_state(m, enable, load, data_in, lz_en);
      sb.push_back(exp_of(next_state(m, enable, load, data_in, lz_en)));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && sb.size() > 0)
      check_val("scan", {23'd0, nibble, digit_an_n, frame_tick}, {23'd0, sb.pop_front()});
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_pos(input int i, input int c);
    int k;
    k = 0;
    while (!(m.idx == i && m.cnt == c) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("wait_pos", m.idx * 100 + m.cnt, i * 100 + c);
  endtask

  task automatic wait_tick(output int at);
    int k;
    k = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("tick_seen", {31'd0, frame_tick}, 32'd1);
    at = cyc;
  endtask

  task automatic load_word(input logic [15:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Count lit cycles per digit over one frame, starting at the current cycle
  task automatic count_frame();
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    for (int i = 0; i < N * RD; i++) begin
      for (int d = 0; d < 4; d++)
        if (digit_an_n[d] == 1'b0) lit_cnt[d]++;
      @(negedge clk);
    end
  endtask

  task automatic check_lits(input string tag, input int e3, input int e2, input int e1, input int e0);
    check_val({tag, "_d3"}, lit_cnt[3], e3);
    check_val({tag, "_d2"}, lit_cnt[2], e2);
    check_val({tag, "_d1"}, lit_cnt[1], e1);
    check_val({tag, "_d0"}, lit_cnt[0], e0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t1;
    int t2;

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_an", digit_an_n, 4'hF);
    check_val("rst_nib", nibble, 4'h0);
    check_val("rst_tick", frame_tick, 1'b0);
    rst_n = 1'b1;

    // 1: load while disabled, then scan 1234
    enable = 1'b0;
    load_word(16'h1234);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_tick(t1);
    wait_tick(t2);
    check_val("tick_period", t2 - t1, N * RD);
    $display("[TB] scan 1234, frame period %0d cycles", t2 - t1);

    // 3: mid-frame load does not tear; wrap-cycle load shows in the new frame
    wait_pos(1, 3);
    load_word(16'hBEEF);
    wait_pos(2, 4);
    check_val("old_d2", nibble, 4'h2);
    wait_pos(3, 4);
    check_val("old_d3", nibble, 4'h1);
    wait_pos(0, 4);
    check_val("new_d0", nibble, 4'hF);
    wait_pos(3, 4);
    check_val("new_d3", nibble, 4'hB);
    wait_pos(3, 7);
    load_word(16'h5678);
    check_val("wrap_load_d0", nibble, 4'h8);
    check_val("wrap_tick", frame_tick, 1'b1);
    $display("[TB] mid-frame load BEEF and wrap-cycle load 5678");

    // 4: drop enable mid-slot, then restart from digit 0
    wait_pos(2, 5);
    enable = 1'b0;
    @(negedge clk);
    check_val("dis_an", digit_an_n, 4'hF);
    check_val("dis_nib", nibble, 4'h0);
    check_val("dis_tick", frame_tick, 1'b0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check_val("reen_nib", nibble, 4'h8);
    check_val("reen_blank", digit_an_n, 4'hF);
    @(negedge clk);
    check_val("reen_lit", digit_an_n, 4'b1110);
    $display("[TB] enable drop and restart");

    // 2: leading-zero suppression
    lz_en = 1'b1;
    load_word(16'h00A0);
    wait_tick(t1);
    count_frame();
    check_lits("lz_00A0", 0, 0, 6, 6);
    load_word(16'h0000);
    wait_tick(t1);
    count_frame();
    check_lits("lz_0000", 0, 0, 0, 6);
    $display("[TB] leading-zero suppression 00A0 / 0000");

    // 6: lz_en toggled mid-frame takes effect only at the next wrap
    lz_en = 1'b0;
    load_word(16'h0012);
    wait_tick(t1);
    lz_en = 1'b1;
    count_frame();
    check_lits("lz_hold", 6, 6, 6, 6);
    count_frame();
    check_lits("lz_next", 0, 0, 6, 6);
    $display("[TB] lz_en toggle mid-frame");

    // 5: asynchronous reset while digit 3 is lit
    lz_en = 1'b0;
    wait_tick(t1);
    wait_pos(3, 4);
    check_val("pre_rst_an", digit_an_n, 4'b0111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_an", digit_an_n, 4'hF);
    check_val("arst_nib", nibble, 4'h0);
    check_val("arst_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_pos(0, 4);
    check_val("post_rst_nib0", nibble, 4'h0);
    check_val("post_rst_an0", digit_an_n, 4'b1110);
    wait_pos(3, 4);
    check_val("post_rst_nib3", nibble, 4'h0);
    check_val("post_rst_an3", digit_an_n, 4'b0111);
    $display("[TB] async reset mid-slot");

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing scan controller for a bank of common-anode 7-segment digits. It shares one 4-bit hex-to-segment decoder across NUM_DIGITS digits. Each refresh slot it presents one nibble to the decoder's w/x/y/z inputs and drives the matching active-low anode. It sits between the register file / UART debug path that supplies a display word and the board-level display pins.

## Interface
- NUM_DIGITS, 4, digits scanned; data width is 4*NUM_DIGITS.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 16, anti-ghosting blank at the start of each slot; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; 0 = display dark, scan held.
- load  in  1  capture data_in into the pending buffer this cycle.
- data_in  in  4*NUM_DIGITS  display word; digit 0 = bits [3:0] (least significant), digit NUM_DIGITS-1 = most significant.
- lz_en  in  1  leading-zero suppression request.
- nibble  out  4  to decoder; nibble[3]=w (MSB) … nibble[0]=z.
- digit_an_n  out  NUM_DIGITS  active-low anode enables; at most one bit low.
- frame_tick  out  1  one-cycle pulse on frame wrap.

## Operation
- State registers:
  - pending: last loaded word.
  - active: word being displayed.
  - lz_r: lz_en latched per frame.
  - idx: current digit, 0..NUM_DIGITS-1.
  - cnt: slot counter, 0..REFRESH_DIV-1.
- pending <= data_in on every cycle with load=1, independent of enable or scan phase.
- Scan (enable=1):
  - cnt increments each cycle.
  - At cnt=REFRESH_DIV-1, cnt <= 0 and idx <= idx+1 mod NUM_DIGITS.
  - idx sequence is 0,1,…,NUM_DIGITS-1,0.
- Frame wrap (idx NUM_DIGITS-1 → 0, on the edge):
  - active <= (load ? data_in : pending). A same-cycle load is displayed in the new frame.
  - lz_r <= lz_en.
  - frame_tick=1 for the following single cycle.
- Mid-frame loads never alter active, so there is no tearing.
- enable=0: cnt <= 0, idx <= 0, active <= next pending value, lz_r <= lz_en, frame_tick=0, all anodes high. On the first cycle enable=1 the scan starts at digit 0, cnt 0, showing the latest load.
- nibble = active[4*idx+3 : 4*idx] whenever enable was 1 on the last edge, else 0.
- Suppression: digit k>0 is suppressed when lz_r=1 and nibbles k..NUM_DIGITS-1 of active are all zero. Digit 0 is never suppressed, so value 0 shows a single "0".
- digit_an_n[idx]=0 only when all of the following hold:
  - enable was 1 on the last edge;
  - cnt ≥ BLANK_CYCLES;
  - digit idx is not suppressed.
  - All other anode bits are 1.
- All outputs are registered, or decoded only from registered state; no input-to-output combinational path.

## Timing
- Reset (async assert, sync release via the clk edge):
  - idx=0, cnt=0, pending=0, active=0, lz_r=0.
  - nibble=0, digit_an_n=all 1s, frame_tick=0.
- Slot length REFRESH_DIV cycles: BLANK_CYCLES dark, then REFRESH_DIV-BLANK_CYCLES lit.
- Frame period NUM_DIGITS*REFRESH_DIV cycles; frame_tick period is identical.
- nibble changes on the same edge idx changes, while the anode is already high (blank window), so the decoder settles before the anode turns on.
- Load-to-display latency: from the load cycle to the next wrap edge, then BLANK_CYCLES more before digit 0 lights. Worst case NUM_DIGITS*REFRESH_DIV + BLANK_CYCLES cycles.
- Reset asserted mid-slot: outputs go to reset values immediately, without waiting for a clock edge.
- enable dropping mid-slot: anodes are high on the next edge.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.

1. Reset, then load data_in=16'h1234 with enable=0, then enable=1.
   - idx steps 0,1,2,3 every 8 cycles; nibble=4,3,2,1.
   - digit_an_n = 1110, 1101, 1011, 0111, each low for cycles 2..7 of its slot.
   - frame_tick pulses every 32 cycles.
2. Display 16'h00A0 with lz_en=1.
   - Digits 3 and 2 stay dark; digit 1 shows A; digit 0 shows 0.
   - Repeat with 16'h0000: only digit 0 lights.
3. Load 16'hBEEF while idx=1 mid-frame.
   - Digits 2 and 3 still show the old word.
   - From the next wrap all digits show BEEF.
   - A load in the exact wrap cycle appears in that new frame.
4. Drop enable at idx=2, cnt=5.
   - The next edge gives digit_an_n=1111, nibble=0, frame_tick=0.
   - On re-enable the scan restarts at idx 0, cnt 0.
5. Assert rst_n=0 between edges while digit 3 is lit.
   - digit_an_n=1111 and nibble=0 immediately; pending/active cleared.
   - After release, 16'h0000 is displayed until a load.
6. Toggle lz_en mid-frame with 16'h0012.
   - Suppression changes only at the next frame wrap.
